// File: rtl/bp_fe_dual_issue_queue.sv
// Dual-issue FE queue: circular buffer filled one packet per cycle by FE fetch,
// presenting up to the two oldest packets per cycle to the BE scheduler.
module bp_fe_dual_issue_queue #(
   parameter int fe_queue_width_p = 128,
   parameter int els_p            = 8
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   input  logic [fe_queue_width_p-1:0]       enq_pkt_i,
   input  logic                              enq_solo_i,
   input  logic                              enq_v_i,
   output logic                              enq_ready_o,
   input  logic                              flush_i,
   output logic [fe_queue_width_p-1:0]       fe_queue1_o,
   output logic [fe_queue_width_p-1:0]       fe_queue2_o,
   output logic                              fe_queue_v1_o,
   output logic                              fe_queue_v2_o,
   input  logic                              fe_queue_ready_i,
   output logic [$clog2(els_p+1)-1:0]        count_o
);

   localparam int ptr_w = $clog2(els_p);
   localparam int cnt_w = $clog2(els_p+1);

   // Handshakes: an enqueue is taken when enq_v_i & enq_ready_o (unless flushed);
   // every slot presented valid is consumed when fe_queue_ready_i is high.
   logic [fe_queue_width_p-1:0] pkt_mem [els_p];
   logic [els_p-1:0]            solo_mem;

   logic [ptr_w-1:0] rptr, wptr, rptr_p1;
   logic [cnt_w-1:0] count, count_next;
   logic             acc_enq;
   logic [1:0]       ndeq;

   assign rptr_p1       = rptr + ptr_w'(1);
   assign enq_ready_o   = (count != cnt_w'(els_p));
   assign fe_queue_v1_o = (count != '0);
   // A solo entry in either head position keeps slot 2 empty.
   assign fe_queue_v2_o = (count >= cnt_w'(2)) & ~solo_mem[rptr] & ~solo_mem[rptr_p1];
   assign fe_queue1_o   = pkt_mem[rptr];
   assign fe_queue2_o   = pkt_mem[rptr_p1];
   assign count_o       = count;

   assign acc_enq    = enq_v_i & enq_ready_o;
   assign ndeq       = fe_queue_ready_i ? ({1'b0, fe_queue_v1_o} + {1'b0, fe_queue_v2_o}) : 2'd0;
   assign count_next = count + cnt_w'(acc_enq) - cnt_w'(ndeq);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else if (flush_i) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         rptr  <= rptr + ptr_w'(ndeq);
         if (acc_enq) wptr <= wptr + ptr_w'(1);
         count <= count_next;
      end
   end

   // Storage is left unreset; outputs are only meaningful under their valids.
   always_ff @(posedge clk_i) begin
      if (acc_enq && !flush_i) begin
         pkt_mem[wptr]  <= enq_pkt_i;
         solo_mem[wptr] <= enq_solo_i;
      end
   end

endmodule
